// File: rtl/frame_pkg.sv
// Shared types and constants for the frame extractor slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_pkg;

   // Extractor FSM states; CKSUM is only reachable when FRAME_CKSUM_EN is defined.
   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CKSUM   = 2'd2
   } state_t;

   // All-ones source for the default header marker; sliced to DATA_W by users.
   localparam logic [63:0] HDR_WORD_DFLT = '1;

   // Width of the completed-frame counter.
   localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/frame_hdr_match.sv
// Counts consecutive header words; flags the word that completes a header.
// Latency: combinational hit on the completing word, count updates on the edge.
// Backpressure: none; every valid word is consumed.
module frame_hdr_match
   import frame_pkg::*;
#(
   parameter int              DATA_W   = 16,
   parameter logic [DATA_W-1:0] HDR_WORD = HDR_WORD_DFLT[DATA_W-1:0],
   parameter int              HDR_LEN  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              hdr_hit
);

   localparam int HCW = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;

   logic [HCW-1:0] hdr_cnt;
   logic           is_hdr;
   logic           at_last;

   assign is_hdr  = (in_data == HDR_WORD);
   assign at_last = (hdr_cnt == HCW'(HDR_LEN - 1));
   // The hit is combinational so the FSM can leave HUNT on the same edge.
   assign hdr_hit = in_valid && is_hdr && at_last;

   // Advance on each header word, restart on any other word or on completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_cnt <= '0;
      end else if (in_valid) begin
         if (!is_hdr || at_last)
            hdr_cnt <= '0;
         else
            hdr_cnt <= hdr_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/frame_extractor.sv
// Detects HDR_LEN header words, forwards PAY_LEN payload words with first/last
// flags and counts frames; FRAME_CKSUM_EN adds a trailing checksum word check.
// Latency 1 cycle (registered outputs); no backpressure, every valid word consumed.
module frame_extractor
   import frame_pkg::*;
#(
   parameter int              DATA_W   = 16,
   parameter logic [DATA_W-1:0] HDR_WORD = HDR_WORD_DFLT[DATA_W-1:0],
   parameter int              HDR_LEN  = 3,
   parameter int              PAY_LEN  = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   output logic                   out_first,
   output logic                   out_last,
   output logic                   frame_done,
   output logic                   frame_err,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int PCW = (PAY_LEN > 1) ? $clog2(PAY_LEN) : 1;

   state_t         state;
   logic [PCW-1:0] pay_cnt;
   logic           hdr_hit;
   logic           pay_first;
   logic           pay_last;
`ifdef FRAME_CKSUM_EN
   logic [DATA_W-1:0] acc;
`endif

   frame_hdr_match #(
      .DATA_W   (DATA_W),
      .HDR_WORD (HDR_WORD),
      .HDR_LEN  (HDR_LEN)
   ) u_hdr_match (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid && (state == HUNT)),
      .hdr_hit  (hdr_hit)
   );

   assign pay_first = (pay_cnt == '0);
   assign pay_last  = (pay_cnt == PCW'(PAY_LEN - 1));

`ifndef FRAME_CKSUM_EN
   assign frame_err = 1'b0;
`endif

   // Frame FSM with registered outputs; output strobes default low every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         pay_cnt    <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
`ifdef FRAME_CKSUM_EN
         frame_err  <= 1'b0;
         acc        <= '0;
`endif
      end else begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
`ifdef FRAME_CKSUM_EN
         frame_err  <= 1'b0;
`endif
         case (state)
            HUNT: begin
               if (hdr_hit) begin
                  state   <= PAYLOAD;
                  pay_cnt <= '0;
`ifdef FRAME_CKSUM_EN
                  acc     <= '0;
`endif
               end
            end
            PAYLOAD: begin
               if (in_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= in_data;
                  out_first <= pay_first;
                  out_last  <= pay_last;
                  pay_cnt   <= pay_cnt + 1'b1;
`ifdef FRAME_CKSUM_EN
                  acc       <= acc + in_data;
                  if (pay_last)
                     state <= CKSUM;
`else
                  if (pay_last) begin
                     state      <= HUNT;
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 1'b1;
                  end
`endif
               end
            end
`ifdef FRAME_CKSUM_EN
            CKSUM: begin
               // Checksum word is consumed here and never forwarded.
               if (in_valid) begin
                  state      <= HUNT;
                  frame_done <= 1'b1;
                  frame_err  <= (in_data != acc);
                  frame_cnt  <= frame_cnt + 1'b1;
               end
            end
`endif
            default: state <= HUNT;
         endcase
      end
   end

endmodule
